// File: rtl/syscall_sequencer_if.sv
// ---------------------------------------------------------------------------
// syscall_sequencer_if
//   Bus bundle between the SYSCALL sequencer and its two peers: the data
//   memory word-read port (req/ack) and the console character stream
//   (valid/ready).
//
//   Signals
//     mem_req     sequencer -> memory   word read request
//     mem_addr    sequencer -> memory   word-aligned byte address (ADDR_W)
//     mem_ack     memory -> sequencer   read data valid this cycle
//     mem_rdata   memory -> sequencer   32-bit read word
//     char_out    sequencer -> console  character byte
//     char_valid  sequencer -> console  character valid
//     char_ready  console -> sequencer  console accepts character
//
//   Modports
//     master  the sequencer side
//     slave   the memory/console side
// ---------------------------------------------------------------------------
interface syscall_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic [7:0]        char_out;
  logic              char_valid;
  logic              char_ready;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata,
    output char_out,
    output char_valid,
    input  char_ready
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata,
    input  char_out,
    input  char_valid,
    output char_ready
  );
endinterface

// File: rtl/syscall_sequencer.sv
// ---------------------------------------------------------------------------
// syscall_sequencer
//   Clocked multi-cycle handler for the SYSCALL instruction. While a service
//   is in progress it holds the PC and register file (stall). The
//   print-string service (v0 = 4) walks a NUL-terminated string in data
//   memory one byte per word fetch and pushes each character to the console.
//   Service v0 = 10 halts the program for good. Any other service pulses
//   unsup and retires the instruction.
//
//   Optional build macro
//     SYSCALL_PRINT_HEX_EN  when defined, service v0 = 34 prints a0 as eight
//                           lowercase hex digits (MSB nibble first) without
//                           touching memory. When undefined, v0 = 34 is
//                           unsupported like any other unknown service.
//
//   Parameters
//     MAX_LEN  max characters emitted by one print-string (truncates)
//     ADDR_W   memory address width
//
//   Ports
//     clk      system clock, rising edge
//     reset    asynchronous active-high reset
//     syscall  decoder flag, high while a SYSCALL is the current instruction
//     vreg     $v0 read port, selects the service
//     areg     $a0 read port, string base address / hex value
//     bus      memory req/ack port and console valid/ready stream (master)
//     stall    freeze PC and register writes
//     halt     sticky, program finished
//     unsup    one-cycle pulse on an unsupported service number
// ---------------------------------------------------------------------------
module syscall_sequencer #(
  parameter int MAX_LEN = 256,
  parameter int ADDR_W  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                syscall,
  input  logic [31:0]         vreg,
  input  logic [31:0]         areg,
  syscall_sequencer_if.master bus,
  output logic                stall,
  output logic                halt,
  output logic                unsup
);

  localparam int CNT_W = (MAX_LEN < 2) ? 1 : $clog2(MAX_LEN + 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_EMIT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_HALT  = 3'd5;

  localparam logic [31:0] SVC_PRINT_STR = 32'd4;
  localparam logic [31:0] SVC_EXIT      = 32'd10;
`ifdef SYSCALL_PRINT_HEX_EN
  localparam logic [31:0] SVC_PRINT_HEX = 32'd34;
`endif

  // Big-endian byte lane: address offset 0 is the most significant byte.
  function automatic logic [7:0] lane_byte(input logic [31:0] word,
                                           input logic [1:0]  lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

`ifdef SYSCALL_PRINT_HEX_EN
  // Lowercase ASCII hex digit.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    logic [7:0] c;
    if (nib < 4'd10) c = 8'h30 + {4'd0, nib};
    else             c = 8'h57 + {4'd0, nib};   // 'a' - 10
    return c;
  endfunction
`endif

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q,   ptr_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [7:0]        char_q,  char_d;
  logic              halt_q,  halt_d;
  logic              unsup_q, unsup_d;
`ifdef SYSCALL_PRINT_HEX_EN
  logic              hex_mode_q, hex_mode_d;
  logic [31:0]       hex_q,      hex_d;
  logic [2:0]        hex_cnt_q,  hex_cnt_d;
`endif

  logic       mem_req_w;
  logic [7:0] rd_byte;

  assign rd_byte = lane_byte(bus.mem_rdata, ptr_q[1:0]);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    char_d  = char_q;
    halt_d  = halt_q;
    unsup_d = 1'b0;
`ifdef SYSCALL_PRINT_HEX_EN
    hex_mode_d = hex_mode_q;
    hex_d      = hex_q;
    hex_cnt_d  = hex_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (syscall && !halt_q) begin
          ptr_d = ADDR_W'(areg);
          cnt_d = '0;
`ifdef SYSCALL_PRINT_HEX_EN
          hex_mode_d = 1'b0;
`endif
          if (vreg == SVC_PRINT_STR) begin
            state_d = ST_FETCH;
          end else if (vreg == SVC_EXIT) begin
            halt_d  = 1'b1;
            state_d = ST_HALT;
`ifdef SYSCALL_PRINT_HEX_EN
          end else if (vreg == SVC_PRINT_HEX) begin
            // First digit goes straight out; hex_q holds the remaining
            // nibbles left-justified so the next digit is always [31:28].
            hex_mode_d = 1'b1;
            char_d     = hex_ascii(areg[31:28]);
            hex_d      = areg << 4;
            hex_cnt_d  = 3'd0;
            state_d    = ST_EMIT;
`endif
          end else begin
            unsup_d = 1'b1;
            state_d = ST_DONE;
          end
        end
      end

      ST_FETCH: begin
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (bus.mem_ack) begin
          if (rd_byte == 8'h00) begin
            state_d = ST_DONE;
          end else begin
            char_d  = rd_byte;
            state_d = ST_EMIT;
          end
        end
      end

      ST_EMIT: begin
        if (bus.char_ready) begin
`ifdef SYSCALL_PRINT_HEX_EN
          if (hex_mode_q) begin
            char_d    = hex_ascii(hex_q[31:28]);
            hex_d     = hex_q << 4;
            hex_cnt_d = hex_cnt_q + 3'd1;
            state_d   = (hex_cnt_q == 3'd7) ? ST_DONE : ST_EMIT;
          end else
`endif
          begin
            // The word is re-fetched for every byte; nothing is cached.
            ptr_d   = ptr_q + ADDR_W'(1);
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = ((cnt_q + CNT_W'(1)) == CNT_W'(MAX_LEN)) ? ST_DONE
                                                               : ST_FETCH;
          end
        end
      end

      // Retire cycle: stall drops so the PC advances; syscall is ignored.
      ST_DONE: begin
        state_d = ST_IDLE;
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      char_q  <= 8'h00;
      halt_q  <= 1'b0;
      unsup_q <= 1'b0;
`ifdef SYSCALL_PRINT_HEX_EN
      hex_mode_q <= 1'b0;
      hex_q      <= '0;
      hex_cnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      char_q  <= char_d;
      halt_q  <= halt_d;
      unsup_q <= unsup_d;
`ifdef SYSCALL_PRINT_HEX_EN
      hex_mode_q <= hex_mode_d;
      hex_q      <= hex_d;
      hex_cnt_q  <= hex_cnt_d;
`endif
    end
  end

  // Outputs decode straight from state so reset clears them immediately,
  // and mem_req / char_valid come from disjoint states.
  assign mem_req_w      = (state_q == ST_FETCH) || (state_q == ST_WAIT);
  assign bus.mem_req    = mem_req_w;
  assign bus.mem_addr   = mem_req_w ? {ptr_q[ADDR_W-1:2], 2'b00} : '0;
  assign bus.char_valid = (state_q == ST_EMIT);
  assign bus.char_out   = char_q;
  assign halt           = halt_q;
  assign unsup          = unsup_q;

  // Combinational so the SYSCALL cycle itself already holds the PC.
  assign stall = (syscall && (state_q == ST_IDLE) && !halt_q) ||
                 (state_q == ST_FETCH) || (state_q == ST_WAIT) ||
                 (state_q == ST_EMIT);

endmodule
